// File: rtl/button_debouncer.sv
//------------------------------------------------------------------------------
// button_debouncer : synchronizes a raw push-button and filters contact bounce.
// Optional DEBOUNCE_HOLD_EN adds a long-press pulse output (hold_o).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module button_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000000
`ifdef DEBOUNCE_HOLD_EN
  ,
  parameter int HOLD_CYCLES   = 200000000
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic btn_o,
  output logic busy_o
`ifdef DEBOUNCE_HOLD_EN
  ,
  output logic hold_o
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   btn_q, btn_d;
  logic                   busy_q, busy_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      busy_q  <= busy_d;
    end
  end

  // Any sample that returns to the current level drops the count to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    btn_d   = btn_q;
    case (state_q)
      STABLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HIGH;
          btn_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LOW;
          btn_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
        btn_d   = 1'b0;
      end
    endcase
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  assign btn_o  = btn_q;
  assign busy_o = busy_q;

`ifdef DEBOUNCE_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic [HOLD_W-1:0] hold_cnt_q;
  logic              hold_q;

  // Saturating at HOLD_CYCLES guarantees a single pulse per stable press.
  always_ff @(posedge clk_i) begin
    if (rst_i || (state_q != STABLE_HIGH)) begin
      hold_cnt_q <= '0;
      hold_q     <= 1'b0;
    end else begin
      hold_q <= (hold_cnt_q == HOLD_LAST);
      if (hold_cnt_q != HOLD_MAX) begin
        hold_cnt_q <= hold_cnt_q + HOLD_ONE;
      end
    end
  end

  assign hold_o = hold_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
//------------------------------------------------------------------------------
// tb_button_debouncer : scoreboard bench with a run-length reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_button_debouncer;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 4;
  localparam int HOLD_CYCLES   = 10;

  logic clk   = 1'b0;
  logic rst_i = 1'b1;
  logic btn_i = 1'b0;
  logic btn_o;
  logic busy_o;
  logic hold_o;

  always #5 clk = ~clk;

`ifdef DEBOUNCE_HOLD_EN
  button_debouncer #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .btn_i (btn_i),
    .btn_o (btn_o),
    .busy_o(busy_o),
    .hold_o(hold_o)
  );
`else
  button_debouncer #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .btn_i (btn_i),
    .btn_o (btn_o),
    .busy_o(busy_o)
  );
  assign hold_o = 1'b0;
`endif

  typedef struct packed {
    logic btn;
    logic busy;
    logic hold;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference: btn_o flips once the synchronized input has disagreed with it
  // for STABLE_CYCLES consecutive edges; busy means a disagreement run is open.
  bit pipe [SYNC_STAGES];
  bit level    = 1'b0;
  int run      = 0;
  int hold_run = 0;

  always @(posedge clk) begin : model
    exp_t e;
    bit   s;
    bit   was_stable_high;
    e = '0;
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) pipe[i] = 1'b0;
      level    = 1'b0;
      run      = 0;
      hold_run = 0;
    end else begin
      s = pipe[SYNC_STAGES-1];
      for (int i = SYNC_STAGES - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = btn_i;
      was_stable_high = level && (run == 0);
      if (was_stable_high) begin
        hold_run++;
        e.hold = (hold_run == HOLD_CYCLES);
      end else begin
        hold_run = 0;
      end
      if (s != level) begin
        run++;
        if (run == STABLE_CYCLES) begin
          level = !level;
          run   = 0;
        end
      end else begin
        run = 0;
      end
      e.btn  = level;
      e.busy = (run != 0);
    end
    exp_q.push_back(e);
  end

  task automatic check(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("btn_o", btn_o, e.btn);
      check("busy_o", busy_o, e.busy);
`ifdef DEBOUNCE_HOLD_EN
      check("hold_o", hold_o, e.hold);
`endif
    end
  end

  task automatic seg(input bit lvl, input int n, input bit r = 1'b0);
    btn_i = lvl;
    rst_i = r;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_i = 1'b1;
    btn_i = 1'b1;
    repeat (3) @(negedge clk);
    seg(1, 10);                        // rise after reset with input already high
    seg(0, 12);
    seg(1, 12); seg(0, 12);            // clean press and release
    seg(1, 3); seg(0, 2); seg(1, 12);  // bounce on press
    seg(0, 12);
    seg(1, 1); seg(0, 10);             // single-cycle glitch
    seg(1, 4); seg(1, 2, 1'b1); seg(1, 12);  // reset mid-qualification
    seg(0, 12);
    seg(1, 6 + 30); seg(0, 12);        // long press
    seg(1, 6 + 8);  seg(0, 12);        // press too short for hold
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) < 3) begin
        seg(1'($urandom_range(0, 1)), $urandom_range(1, 3), 1'b1);
      end else if ($urandom_range(0, 9) == 0) begin
        seg(1'($urandom_range(0, 1)), $urandom_range(8, 20));
      end else begin
        seg(1'($urandom_range(0, 1)), $urandom_range(1, 7));
      end
    end
    seg(0, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions a raw, asynchronous push-button input for the clock's time-setting controls.
- Synchronizes the input into clk_i and filters contact bounce.
- Produces a clean level that feeds directly into the edge detector stage, which turns it into rising/falling pulses.
- Placed one instance per physical button, upstream of the edge detector.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range >= 2.
- STABLE_CYCLES, 1000000, consecutive synchronized samples at a new value required before btn_o changes; legal range >= 2.
- CNT_W, $clog2(STABLE_CYCLES+1), debounce counter width; derived, not overridden.

Ports:
- clk_i  input  1  system clock; all logic on its rising edge.
- rst_i  input  1  synchronous reset, active-high.
- btn_i  input  1  raw button level; asynchronous, may bounce.
- btn_o  output  1  debounced, synchronized button level.
- busy_o  output  1  high while a candidate level change is being qualified.

Behaviour:
- Reset, with rst_i high at a clk_i edge:
  - all sync flops, btn_o, busy_o and the counter go to 0; state = STABLE_LOW.
  - Reset overrides every other event, including mid-qualification; the count in progress is discarded.
- Synchronizer: btn_i passes through SYNC_STAGES flops; s = last stage. No other logic touches btn_i.
- States: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
- STABLE_LOW:
  - s==1 -> WAIT_HIGH, cnt<=1.
  - else hold.
- WAIT_HIGH:
  - s==0 (bounce) -> STABLE_LOW, cnt<=0, btn_o unchanged.
  - s==1 and cnt==STABLE_CYCLES-1 -> STABLE_HIGH, btn_o<=1, cnt<=0.
  - otherwise cnt<=cnt+1.
- STABLE_HIGH and WAIT_LOW: mirror image of the two states above, with values inverted.
- Outputs:
  - btn_o is registered and driven only by the state machine.
  - busy_o = registered (state is WAIT_HIGH or WAIT_LOW).
- Latency: for a clean change held stable, btn_o updates at the (SYNC_STAGES+STABLE_CYCLES)-th clk_i edge, counting the first edge that samples btn_i at its new value as edge 1.
- Any return of s to the current btn_o level during WAIT restarts qualification from zero. There is no partial credit.
- Counter never exceeds STABLE_CYCLES-1; no wrap-around possible.
- btn_o toggles at most once per STABLE_CYCLES cycles; it never changes while busy_o was low on the previous cycle.
- After reset release with btn_i already high: normal full qualification; btn_o rises per the latency rule.

Optional Feature:
- Macro: DEBOUNCE_HOLD_EN.
- Defined:
  - adds parameter HOLD_CYCLES (default 200000000) and output hold_o (1 bit, reset 0).
  - A hold counter runs while state == STABLE_HIGH; it clears on leaving STABLE_HIGH and on reset.
  - hold_o is a single-cycle pulse on the cycle the counter reaches HOLD_CYCLES, i.e. the HOLD_CYCLES-th edge after btn_o rose.
  - At most one pulse per press; no pulse if the press ends earlier; nothing on release.
- Undefined: no hold_o port, no hold counter; behaviour otherwise identical.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=4, HOLD_CYCLES=10):
1. Reset: rst_i=1 for 3 cycles with btn_i=1 -> btn_o=0, busy_o=0 throughout; after release btn_o rises at edge 6, counting the first post-reset edge as 1.
2. Clean press: btn_i 0->1 held -> busy_o=1 after edges 3,4,5; btn_o=1 and busy_o=0 after edge 6. Clean release gives the mirror response, with btn_o=0 after edge 6.
3. Bounce: btn_i high 3 cycles, low 2, then high held -> btn_o stays 0 until edge 6 after the final rise, then 1.
4. Glitch: single-cycle btn_i=1 pulse -> busy_o high exactly 1 cycle; btn_o stays 0.
5. Reset mid-qualification: assert rst_i after edge 4 of a press, release while btn_i stays high -> btn_o=0 during reset; rises at edge 6 after release.
6. DEBOUNCE_HOLD_EN:
   - press held 30 cycles -> exactly one hold_o pulse, 10 edges after btn_o rises.
   - press held 8 cycles after btn_o rises -> no pulse.
